// File: rtl/alu_in_pkg_hdl.sv
// rtl/alu_in_pkg_hdl.sv - shared ALU operation codes, width defaults and FSM state type
//
// Purpose: single home for the ALU opcode enum and the default operand/result
// widths so that the core, the multiplier and any bench agree on encodings.
// Ports: none (package).

package alu_in_pkg_hdl;

  localparam int ALU_IN_OP_WIDTH_DEFAULT      = 8;
  localparam int ALU_OUT_RESULT_WIDTH_DEFAULT = 16;

  // Codes 5 and 6 are deliberately unassigned; the core consumes them silently.
  typedef enum logic [2:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4,
    rst_op = 3'd7
  } alu_in_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_core_mul.sv
// rtl/alu_core_mul.sv - registered unsigned multiplier used by alu_core for mul_op
//
// Purpose: captures the operands on start_i and presents the full unsigned
// product two edges later, so the core can latch it on the third edge after
// the accept (done at accept+3).
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    operand capture strobe (one cycle, at accept)
//   a_i, b_i   operands, W bits each
//   product_o  registered product, 2*W bits

module alu_core_mul #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] product_o
);

  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] prod_q, prod_d;

  // Operands are frozen between starts, so later changes on a_i/b_i cannot
  // disturb an operation that is already in flight.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    prod_d = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    if (start_i) begin
      a_d = a_i;
      b_d = b_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
    end
  end

  assign product_o = prod_q;

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - small multi-cycle ALU with IDLE/BUSY/DONE handshake FSM
//
// Purpose: accepts one request per valid&&ready, computes add/and/xor in one
// cycle and (optionally) an unsigned multiply in three, and pulses done for
// one cycle with the registered result.
// Configuration: define ALU_CORE_MUL_EN to build the multiplier; without it
// mul_op is consumed like no_op.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   valid   request strobe
//   alu_op  operation code (alu_in_op_t)
//   a, b    operands, ALU_IN_OP_WIDTH bits
//   ready   high only in IDLE
//   done    one-cycle result-valid pulse
//   result  registered result, ALU_OUT_RESULT_WIDTH bits

module alu_core
  import alu_in_pkg_hdl::*;
#(
  parameter int ALU_IN_OP_WIDTH      = ALU_IN_OP_WIDTH_DEFAULT,
  parameter int ALU_OUT_RESULT_WIDTH = ALU_OUT_RESULT_WIDTH_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid,
  input  logic [2:0]                      alu_op,
  input  logic [ALU_IN_OP_WIDTH-1:0]      a,
  input  logic [ALU_IN_OP_WIDTH-1:0]      b,
  output logic                            ready,
  output logic                            done,
  output logic [ALU_OUT_RESULT_WIDTH-1:0] result
);

  localparam int W  = ALU_IN_OP_WIDTH;
  localparam int RW = ALU_OUT_RESULT_WIDTH;

  alu_state_e      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [RW-1:0]   result_q, result_d;
  logic [W:0]      sum;
  logic [RW-1:0]   mul_product;

  assign sum = {1'b0, a} + {1'b0, b};

`ifdef ALU_CORE_MUL_EN
  logic mul_start;

  alu_core_mul #(
    .W(W)
  ) u_mul (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (mul_start),
    .a_i      (a),
    .b_i      (b),
    .product_o(mul_product)
  );
`else
  assign mul_product = '0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef ALU_CORE_MUL_EN
    mul_start = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (valid) begin
          case (alu_in_op_t'(alu_op))
            add_op: begin
              result_d = {{(RW-W-1){1'b0}}, sum};
              state_d  = ST_DONE;
            end
            and_op: begin
              result_d = {{(RW-W){1'b0}}, a & b};
              state_d  = ST_DONE;
            end
            xor_op: begin
              result_d = {{(RW-W){1'b0}}, a ^ b};
              state_d  = ST_DONE;
            end
`ifdef ALU_CORE_MUL_EN
            mul_op: begin
              mul_start = 1'b1;
              cnt_d     = 2'd2;
              state_d   = ST_BUSY;
            end
`endif
            rst_op: begin
              result_d = '0;
            end
            // no_op, codes 5/6 and (without the multiplier) mul_op are
            // consumed with no visible effect.
            default: ;
          endcase
        end
      end

      ST_BUSY: begin
        // Leaving when the counter reaches 0 puts DONE at accept+3; the
        // multiplier product is valid in this same cycle.
        cnt_d = cnt_q - 2'd1;
        if (cnt_d == 2'd0) begin
          result_d = mul_product;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - directed self-checking bench for alu_core

module tb_alu_core;
  import alu_in_pkg_hdl::*;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [2:0]  alu_op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  alu_core dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .alu_op(alu_op),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    valid  = 1'b1;
    alu_op = op;
    a      = av;
    b      = bv;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; alu_op = 3'd0; a = 8'h00; b = 8'h00;
    step(); step();
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'h0);
    rst = 1'b0;

    // add with carry out
    req(3'(add_op), 8'hFF, 8'h01);
    step();
    valid = 1'b0;
    check("add_done", 32'(done), 32'd1);
    check("add_ready_low", 32'(ready), 32'd0);
    check("add_result", 32'(result), 32'h0100);
    step();
    check("add_done_clear", 32'(done), 32'd0);
    check("add_ready_back", 32'(ready), 32'd1);
    check("add_result_hold", 32'(result), 32'h0100);

    // and
    req(3'(and_op), 8'hF0, 8'h3C);
    step();
    valid = 1'b0;
    check("and_done", 32'(done), 32'd1);
    check("and_result", 32'(result), 32'h0030);
    step();

    // xor then rst_op
    req(3'(xor_op), 8'hA5, 8'h0F);
    step();
    valid = 1'b0;
    check("xor_done", 32'(done), 32'd1);
    check("xor_result", 32'(result), 32'h00AA);
    step();
    req(3'(rst_op), 8'h12, 8'h34);
    step();
    valid = 1'b0;
    check("rstop_done", 32'(done), 32'd0);
    check("rstop_result", 32'(result), 32'h0);
    check("rstop_ready", 32'(ready), 32'd1);
    step();
    check("rstop_done_after", 32'(done), 32'd0);

    // unused code 5, 6 and no_op hold result
    req(3'(add_op), 8'h01, 8'h02);
    step();
    valid = 1'b0;
    step();
    check("pre_unused_result", 32'(result), 32'h3);
    for (int i = 0; i < 3; i++) begin
      logic [2:0] ops [3];
      ops[0] = 3'd5; ops[1] = 3'd6; ops[2] = 3'(no_op);
      req(ops[i], 8'h55, 8'h66);
      step();
      valid = 1'b0;
      check($sformatf("unused%0d_done", i), 32'(done), 32'd0);
      check($sformatf("unused%0d_ready", i), 32'(ready), 32'd1);
      check($sformatf("unused%0d_result", i), 32'(result), 32'h3);
    end

    // back-to-back add with valid held
    req(3'(add_op), 8'd1, 8'd2);
    step();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_result1", 32'(result), 32'd3);
    check("b2b_ready1", 32'(ready), 32'd0);
    a = 8'd3; b = 8'd4;
    step();
    check("b2b_gap_done", 32'(done), 32'd0);
    check("b2b_gap_ready", 32'(ready), 32'd1);
    step();
    valid = 1'b0;
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_result2", 32'(result), 32'd7);
    step();
    check("b2b_idle_done", 32'(done), 32'd0);

    // multiply FF*FF, operands changed while busy
    req(3'(mul_op), 8'hFF, 8'hFF);
    step();
    valid = 1'b0; a = 8'h00; b = 8'h00;
`ifdef ALU_CORE_MUL_EN
    check("mul_c1_ready", 32'(ready), 32'd0);
    check("mul_c1_done", 32'(done), 32'd0);
    step();
    check("mul_c2_ready", 32'(ready), 32'd0);
    check("mul_c2_done", 32'(done), 32'd0);
    step();
    check("mul_c3_ready", 32'(ready), 32'd0);
    check("mul_c3_done", 32'(done), 32'd1);
    check("mul_result", 32'(result), 32'hFE01);
    step();
    check("mul_after_ready", 32'(ready), 32'd1);
    check("mul_after_done", 32'(done), 32'd0);
    check("mul_after_result", 32'(result), 32'hFE01);
`else
    for (int i = 0; i < 4; i++) begin
      check($sformatf("nomul_c%0d_ready", i + 1), 32'(ready), 32'd1);
      check($sformatf("nomul_c%0d_done", i + 1), 32'(done), 32'd0);
      check($sformatf("nomul_c%0d_result", i + 1), 32'(result), 32'd7);
      step();
    end
`endif

    // rst one cycle after a mul accept aborts it
    req(3'(mul_op), 8'd3, 8'd5);
    step();
    valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("abort_nodone%0d", i), 32'(done), 32'd0);
    end
    check("abort_result_end", 32'(result), 32'h0);

    // rst coincident with an accept drops the request
    req(3'(add_op), 8'h01, 8'h02);
    step();
    valid = 1'b0;
    step();
    check("coinc_pre_result", 32'(result), 32'h3);
    req(3'(add_op), 8'h05, 8'h05);
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid = 1'b0;
    check("coinc_done", 32'(done), 32'd0);
    check("coinc_result", 32'(result), 32'h0);
    step();
    check("coinc_done_after", 32'(done), 32'd0);
    check("coinc_result_after", 32'(result), 32'h0);

    // rst during DONE clears result and ends the pulse
    req(3'(add_op), 8'h10, 8'h20);
    step();
    valid = 1'b0;
    check("rstdone_pre_done", 32'(done), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstdone_done", 32'(done), 32'd0);
    check("rstdone_result", 32'(result), 32'h0);
    check("rstdone_ready", 32'(ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter ALU_IN_OP_WIDTH, default 8, operand width; SHALL be >= 2.
REQ-002 Parameter ALU_OUT_RESULT_WIDTH, default 16, result width; SHALL equal 2*ALU_IN_OP_WIDTH.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 valid  in  1  request strobe; operands and op are sampled when valid&&ready.
REQ-007 alu_op  in  3  operation code (alu_in_op_t).
REQ-008 a  in  ALU_IN_OP_WIDTH  operand A.
REQ-009 b  in  ALU_IN_OP_WIDTH  operand B.
REQ-010 ready  out  1  block can accept a request this cycle.
REQ-011 done  out  1  one-cycle pulse, result valid; drives the alu_out bus done signal.
REQ-012 result  out  ALU_OUT_RESULT_WIDTH  operation result; drives the alu_out bus result signal.

Function
REQ-013 FSM states are IDLE, BUSY, DONE; ready SHALL be 1 only in IDLE.
REQ-014 Accept = valid&&ready; no other cycle SHALL sample a, b or alu_op.
REQ-015 Accepting add_op, and_op or xor_op SHALL go IDLE->DONE; done=1 exactly 1 cycle after accept.
REQ-016 Accepting mul_op SHALL go IDLE->BUSY; a 2-bit counter loads 2 and decrements each cycle; at 0 -> DONE; done=1 exactly 3 cycles after accept.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE; done SHALL be 0 in every other state.
REQ-018 add: result = zero-extended (a+b), carry kept in bit ALU_IN_OP_WIDTH; and/xor: zero-extended bitwise; mul: full unsigned a*b.
REQ-019 result SHALL update only in the cycle done rises, and SHALL hold its value until the next done or rst_op.
REQ-020 no_op and the unused codes 5 and 6 SHALL be accepted and consumed with no done pulse, staying in IDLE.
REQ-021 rst_op SHALL be accepted, clear result to 0 on the next edge, produce no done pulse, and stay in IDLE.
REQ-022 valid held high across back-to-back add_op requests SHALL give one accept every 2 cycles.
REQ-023 Operand changes while in BUSY or DONE SHALL NOT affect the in-flight result.

Reset
REQ-024 rst=1 SHALL force state=IDLE, counter=0, done=0, result=0, ready=1 on the next edge.
REQ-025 rst asserted in BUSY or DONE SHALL abort the operation; no done pulse SHALL follow for it.
REQ-026 rst SHALL take priority over a coincident accept; that request is dropped.

Configuration
REQ-027 Macro ALU_CORE_MUL_EN defined: the multiplier SHALL be built and mul_op SHALL behave as in REQ-016.
REQ-028 Macro ALU_CORE_MUL_EN undefined: no multiplier logic SHALL exist, and mul_op SHALL be treated as no_op (accepted, no done, result unchanged).

Structure
REQ-029 The alu_in_op_t enum (no_op=0, add_op=1, and_op=2, xor_op=3, mul_op=4, rst_op=7) SHALL live in the shared package alu_in_pkg_hdl.
REQ-030 The ALU_IN_OP_WIDTH and ALU_OUT_RESULT_WIDTH defaults SHALL also live in alu_in_pkg_hdl.
REQ-031 The multiplier SHALL be the sub-module alu_core_mul: 3-cycle latency, instantiated only under ALU_CORE_MUL_EN.
REQ-032 FSM and result register SHALL stay in alu_core.

Verification
REQ-033 add_op a=8'hFF b=8'h01 -> done 1 cycle after accept, result=16'h0100.
REQ-034 mul_op a=8'hFF b=8'hFF with ALU_CORE_MUL_EN -> ready low 3 cycles, done at accept+3, result=16'hFE01; without the macro -> no done, result unchanged.
REQ-035 xor_op a=8'hA5 b=8'h0F, then rst_op -> result=16'h00AA with done, then result=0 with no done.
REQ-036 rst pulsed at accept+1 of mul_op -> no done ever, ready=1 the cycle after reset, result=0.
REQ-037 Back-to-back add_op (1+2, 3+4) with valid held -> accepts at t and t+2, done at t+1 and t+3, results 3 then 7.
REQ-038 alu_op=5 and no_op with valid -> accepted, no done, result holds its previous value.
